// File: rtl/stick_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stick_sync_pkg
//  Description : Shared types and default constants for the external sync
//                conditioner (state encoding, default qualification width,
//                hold-off length and counter widths).
//  Revision    : 1.0  initial release
// ============================================================================
package stick_sync_pkg;

   // Conditioner FSM states, explicit 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_QUALIFY = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   // Default qualification width: consecutive high synchronised samples.
   localparam int unsigned MIN_WIDTH_DEF = 8;
   // Default hold-off window after an accepted sync, in sys_clk cycles.
   localparam int unsigned HOLDOFF_DEF   = 1000;
   // Default event counter width.
   localparam int unsigned CNT_W_DEF     = 16;
   // Default period counter width.
   localparam int unsigned PER_W_DEF     = 32;

endpackage : stick_sync_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Single-bit two-flop synchroniser. Brings an asynchronous
//                level into the clk_i domain. Reusable wherever one
//                asynchronous control bit must be sampled.
//  Ports       : clk_i  - destination clock
//                rst_i  - synchronous active-high reset (clears both flops)
//                d_i    - asynchronous input level
//                q_o    - synchronised level (second flop)
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;   // first stage, may go metastable
   logic s2_q;   // second stage, safe to use in logic

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/stick_sync_cond.sv
`default_nettype none
// ============================================================================
//  Module      : stick_sync_cond
//  Description : External sync conditioner. Synchronises the raw sync line,
//                rejects glitches shorter than MIN_WIDTH samples, enforces a
//                hold-off window after each accepted sync and emits one
//                single-cycle pulse per accepted event. Also keeps status
//                counters and the period between accepted syncs.
//  Ports       : sys_clk       - system clock (100 MHz)
//                rst           - synchronous active-high reset
//                i_sync_raw    - asynchronous raw sync line
//                i_enable      - qualification enable
//                o_sync        - single-cycle accepted-sync pulse
//                o_busy        - high whenever the FSM is not IDLE
//                o_sync_cnt    - accepted syncs (wraps)
//                o_glitch_cnt  - pulses dropped before qualifying (saturates)
//                o_reject_cnt  - rising edges during hold-off (saturates)
//                o_period      - cycles between the last two accepted syncs
//                o_period_vld  - two syncs accepted since reset
//  Revision    : 1.0  initial release
// ============================================================================
module stick_sync_cond
   import stick_sync_pkg::*;
#(
   parameter int unsigned MIN_WIDTH = MIN_WIDTH_DEF,
   parameter int unsigned HOLDOFF   = HOLDOFF_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned PER_W     = PER_W_DEF
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             i_sync_raw,
   input  logic             i_enable,
   output logic             o_sync,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_sync_cnt,
   output logic [CNT_W-1:0] o_glitch_cnt,
   output logic [CNT_W-1:0] o_reject_cnt,
   output logic [PER_W-1:0] o_period,
   output logic             o_period_vld
);

   // -------------------------------------------------------------------------
   // Counter widths. Qualification counter must hold MIN_WIDTH itself; the
   // hold-off counter only needs to reach HOLDOFF-1, where it parks.
   // -------------------------------------------------------------------------
   localparam int unsigned QW = (MIN_WIDTH < 1) ? 1 : $clog2(MIN_WIDTH + 1);
   localparam int unsigned HW = (HOLDOFF   < 2) ? 1 : $clog2(HOLDOFF + 1);

   localparam logic [QW-1:0] C_MIN_WIDTH = QW'(MIN_WIDTH);
   localparam logic [HW-1:0] C_HOLD_LAST = (HOLDOFF == 0) ? '0 : HW'(HOLDOFF - 1);
   localparam logic [QW-1:0] C_Q_ONE     = QW'(1);

   // -------------------------------------------------------------------------
   // Synchroniser and edge detect
   // -------------------------------------------------------------------------
   logic s2;
   logic s2_d_q;
   logic rise;

   sync_2ff u_sync_2ff (
      .clk_i (sys_clk),
      .rst_i (rst),
      .d_i   (i_sync_raw),
      .q_o   (s2)
   );

   assign rise = s2 & ~s2_d_q;

   // -------------------------------------------------------------------------
   // State and counters
   // -------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [QW-1:0]    q_cnt_q, q_cnt_d;
   logic [HW-1:0]    h_cnt_q, h_cnt_d;

   logic             accept;     // QUALIFY -> HOLDOFF this cycle
   logic             glitch;     // QUALIFY -> IDLE on a dropped pulse
   logic             reject;     // rising edge while in hold-off

   logic             sync_q;
   logic             busy_q;
   logic [CNT_W-1:0] sync_cnt_q;
   logic [CNT_W-1:0] glitch_cnt_q;
   logic [CNT_W-1:0] reject_cnt_q;
   logic [PER_W-1:0] per_cnt_q;
   logic [PER_W-1:0] period_q;
   logic             seen_one_q; // at least one accept since reset
   logic             period_vld_q;

   // -------------------------------------------------------------------------
   // Next-state / event decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      q_cnt_d = q_cnt_q;
      h_cnt_d = h_cnt_q;
      accept  = 1'b0;
      glitch  = 1'b0;
      reject  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (s2) begin
               state_d = ST_QUALIFY;
               q_cnt_d = C_Q_ONE;
            end
         end

         ST_QUALIFY: begin
            // Once MIN_WIDTH high samples have been counted the event is
            // qualified; the level on this cycle no longer matters.
            if (q_cnt_q >= C_MIN_WIDTH) begin
               accept  = 1'b1;
               state_d = ST_HOLDOFF;
               h_cnt_d = '0;
            end else if (s2) begin
               q_cnt_d = q_cnt_q + 1'b1;
            end else begin
               glitch  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_HOLDOFF: begin
            // Park at the terminal count so the counter never wraps while a
            // line is held high past the window.
            if (h_cnt_q < C_HOLD_LAST) begin
               h_cnt_d = h_cnt_q + 1'b1;
            end
            reject = rise;
            // Requiring the line low means a level still held high after the
            // window cannot re-trigger the conditioner.
            if ((h_cnt_q >= C_HOLD_LAST) && !s2) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disabled: park in IDLE and let no event reach the counters.
      if (!i_enable) begin
         state_d = ST_IDLE;
         accept  = 1'b0;
         glitch  = 1'b0;
         reject  = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         q_cnt_q      <= '0;
         h_cnt_q      <= '0;
         s2_d_q       <= 1'b0;
         sync_q       <= 1'b0;
         busy_q       <= 1'b0;
         sync_cnt_q   <= '0;
         glitch_cnt_q <= '0;
         reject_cnt_q <= '0;
         per_cnt_q    <= '0;
         period_q     <= '0;
         seen_one_q   <= 1'b0;
         period_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         q_cnt_q <= q_cnt_d;
         h_cnt_q <= h_cnt_d;
         s2_d_q  <= s2;
         sync_q  <= accept;
         busy_q  <= (state_d != ST_IDLE);

         // Period counter free-runs regardless of enable; on accept it is
         // captured and restarted at 1 so the captured value is the exact
         // edge-to-edge distance between accepts.
         if (accept) begin
            period_q   <= per_cnt_q;
            per_cnt_q  <= {{(PER_W-1){1'b0}}, 1'b1};
            seen_one_q <= 1'b1;
            if (seen_one_q) begin
               period_vld_q <= 1'b1;
            end
         end else if (per_cnt_q != {PER_W{1'b1}}) begin
            per_cnt_q <= per_cnt_q + 1'b1;
         end

         if (accept) begin
            sync_cnt_q <= sync_cnt_q + 1'b1;
         end
         if (glitch && (glitch_cnt_q != {CNT_W{1'b1}})) begin
            glitch_cnt_q <= glitch_cnt_q + 1'b1;
         end
         if (reject && (reject_cnt_q != {CNT_W{1'b1}})) begin
            reject_cnt_q <= reject_cnt_q + 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign o_sync       = sync_q;
   assign o_busy       = busy_q;
   assign o_sync_cnt   = sync_cnt_q;
   assign o_glitch_cnt = glitch_cnt_q;
   assign o_reject_cnt = reject_cnt_q;
   assign o_period     = period_q;
   assign o_period_vld = period_vld_q;

endmodule : stick_sync_cond
`default_nettype wire

// File: tb/tb_stick_sync_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stick_sync_cond
//  Description : Self-checking bench for stick_sync_cond with default
//                parameters. Single-pulse cases are table driven; hold-off
//                rejection, mid-qualify reset and period measurement are
//                hand-written sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stick_sync_cond;

   localparam int CNT_W = 16;
   localparam int PER_W = 32;
   localparam int LAT   = 11;   // raw set after edge c -> o_sync seen at cycle c+11

   logic             sys_clk;
   logic             rst;
   logic             i_sync_raw;
   logic             i_enable;
   logic             o_sync;
   logic             o_busy;
   logic [CNT_W-1:0] o_sync_cnt;
   logic [CNT_W-1:0] o_glitch_cnt;
   logic [CNT_W-1:0] o_reject_cnt;
   logic [PER_W-1:0] o_period;
   logic             o_period_vld;

   stick_sync_cond dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .i_sync_raw   (i_sync_raw),
      .i_enable     (i_enable),
      .o_sync       (o_sync),
      .o_busy       (o_busy),
      .o_sync_cnt   (o_sync_cnt),
      .o_glitch_cnt (o_glitch_cnt),
      .o_reject_cnt (o_reject_cnt),
      .o_period     (o_period),
      .o_period_vld (o_period_vld)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nsync = 0;
   int last_sync_cyc = -1;
   logic prev_sync = 1'b0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Pulse monitor on the falling edge: counts pulses and checks 1-cycle width.
   always @(negedge sys_clk) begin
      if (o_sync) begin
         nsync         = nsync + 1;
         last_sync_cyc = cyc;
         total         = total + 1;
         if (prev_sync) begin
            bad = bad + 1;
            $display("FAIL sync_width: o_sync high on consecutive cycles at cyc %0d, required 1-cycle pulse", cyc);
         end
      end
      prev_sync = o_sync;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Raw pulse of w cycles; returns the cycle count at which it was raised.
   task automatic pulse(input int w, output int c0);
      i_sync_raw = 1'b1;
      c0 = cyc;
      tick(w);
      i_sync_raw = 1'b0;
   endtask

   typedef struct {
      int width;
      bit en;
      bit exp_pulse;
      int exp_sync;
      int exp_glitch;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int c0;
      int n0;

      vecs[0] = '{width: 20, en: 1'b1, exp_pulse: 1'b1, exp_sync: 1, exp_glitch: 0};
      vecs[1] = '{width:  5, en: 1'b1, exp_pulse: 1'b0, exp_sync: 1, exp_glitch: 1};
      vecs[2] = '{width:  7, en: 1'b1, exp_pulse: 1'b0, exp_sync: 1, exp_glitch: 2};
      vecs[3] = '{width:  8, en: 1'b1, exp_pulse: 1'b1, exp_sync: 2, exp_glitch: 2};
      vecs[4] = '{width: 20, en: 1'b0, exp_pulse: 1'b0, exp_sync: 2, exp_glitch: 2};
      vecs[5] = '{width: 20, en: 1'b1, exp_pulse: 1'b1, exp_sync: 3, exp_glitch: 2};
      vecs[6] = '{width:  1, en: 1'b1, exp_pulse: 1'b0, exp_sync: 3, exp_glitch: 3};

      rst        = 1'b1;
      i_sync_raw = 1'b0;
      i_enable   = 1'b1;
      tick(3);

      // Reset state.
      chk("rst_sync",       o_sync,       0);
      chk("rst_busy",       o_busy,       0);
      chk("rst_sync_cnt",   o_sync_cnt,   0);
      chk("rst_glitch_cnt", o_glitch_cnt, 0);
      chk("rst_reject_cnt", o_reject_cnt, 0);
      chk("rst_period",     o_period,     0);
      chk("rst_period_vld", o_period_vld, 0);
      rst = 1'b0;
      tick(5);

      // Single-pulse table.
      for (int i = 0; i < 7; i++) begin
         n0       = nsync;
         i_enable = vecs[i].en;
         pulse(vecs[i].width, c0);
         tick(4);
         i_enable = 1'b1;
         tick(1100);
         chk($sformatf("v%0d_pulses", i), nsync - n0, vecs[i].exp_pulse ? 1 : 0);
         if (vecs[i].exp_pulse) begin
            chk($sformatf("v%0d_latency", i), last_sync_cyc - c0, LAT);
         end
         chk($sformatf("v%0d_sync_cnt", i),   o_sync_cnt,   vecs[i].exp_sync);
         chk($sformatf("v%0d_glitch_cnt", i), o_glitch_cnt, vecs[i].exp_glitch);
         chk($sformatf("v%0d_reject_cnt", i), o_reject_cnt, 0);
         chk($sformatf("v%0d_busy", i),       o_busy,       0);
      end

      // Two pulses 500 cycles apart: second falls in hold-off.
      n0 = nsync;
      pulse(20, c0);
      tick(480);
      pulse(20, c0);
      tick(1100);
      chk("holdoff_pulses",     nsync - n0,   1);
      chk("holdoff_reject_cnt", o_reject_cnt, 1);
      chk("holdoff_sync_cnt",   o_sync_cnt,   4);
      chk("holdoff_busy",       o_busy,       0);

      // Reset four cycles into QUALIFY; held until the pulse is gone.
      n0 = nsync;
      pulse(7, c0);
      i_sync_raw = 1'b1;
      rst = 1'b1;
      tick(1);
      chk("midrst_busy",       o_busy,       0);
      chk("midrst_sync",       o_sync,       0);
      chk("midrst_sync_cnt",   o_sync_cnt,   0);
      chk("midrst_glitch_cnt", o_glitch_cnt, 0);
      chk("midrst_reject_cnt", o_reject_cnt, 0);
      chk("midrst_period",     o_period,     0);
      chk("midrst_period_vld", o_period_vld, 0);
      tick(12);
      i_sync_raw = 1'b0;
      tick(4);
      rst = 1'b0;
      tick(30);
      chk("midrst_no_pulse", nsync - n0, 0);

      // Three pulses with rising edges 2000 cycles apart.
      n0 = nsync;
      pulse(20, c0);
      tick(1980);
      chk("per1_sync_cnt",   o_sync_cnt,   1);
      chk("per1_period_vld", o_period_vld, 0);
      pulse(20, c0);
      tick(1980);
      chk("per2_period_vld", o_period_vld, 1);
      chk("per2_period",     o_period,     2000);
      pulse(20, c0);
      tick(1100);
      chk("per3_period",     o_period,     2000);
      chk("per3_period_vld", o_period_vld, 1);
      chk("per3_sync_cnt",   o_sync_cnt,   3);
      chk("per3_pulses",     nsync - n0,   3);
      chk("per3_latency",    last_sync_cyc - c0, LAT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_stick_sync_cond
`default_nettype wire
